// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor: computes a - b one bit per clock, LSB first,
// through a single one-bit borrow cell. A start/done handshake frames each
// operation; the difference and final borrow are held until the next
// operation completes.
module subtrator_serial #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         iniciar,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ocupado,
  output logic         pronto,
  output logic [N-1:0] diferenca,
  output logic         emprestimo
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  estado_t       estado;
  logic [N-1:0]  sh_a;
  logic [N-1:0]  sh_b;
  // Bits already produced, aligned to the top; the bit being computed this
  // cycle is appended above them to form the next (or final) result.
  logic [N-2:0]  sh_d;
  logic          br;
  logic [CW-1:0] cnt;

  logic          ai;
  logic          bi;
  logic          d;
  logic          br_nxt;
  logic [N-1:0]  res_nxt;

  // One-bit borrow cell applied to the current LSBs of the operand registers.
  assign ai      = sh_a[0];
  assign bi      = sh_b[0];
  assign d       = ai ^ bi ^ br;
  assign br_nxt  = (~ai & bi) | (~(ai ^ bi) & br);
  assign res_nxt = {d, sh_d};

  // Control FSM and serial datapath; outputs are registered alongside state.
  // NOTE: every register here, datapath included, is cleared by reset so that
  // an aborted operation leaves no stale difference or borrow visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= OCIOSO;
      sh_a       <= '0;
      sh_b       <= '0;
      sh_d       <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      ocupado    <= 1'b0;
      pronto     <= 1'b0;
      diferenca  <= '0;
      emprestimo <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      case (estado)
        OCIOSO: begin
          pronto <= 1'b0;
          if (iniciar) begin
            sh_a    <= a;
            sh_b    <= b;
            sh_d    <= '0;
            br      <= 1'b0;
            cnt     <= '0;
            ocupado <= 1'b1;
            estado  <= CALCULA;
          end
        end

        CALCULA: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          sh_d <= res_nxt[N-1:1];
          br   <= br_nxt;
          if (cnt == LAST) begin
            // Last bit: publish the completed result on the edge into FIM.
            diferenca  <= res_nxt;
            emprestimo <= br_nxt;
            ocupado    <= 1'b0;
            pronto     <= 1'b1;
            estado     <= FIM;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        FIM: begin
          pronto <= 1'b0;
          estado <= OCIOSO;
        end

        default: begin
          ocupado <= 1'b0;
          pronto  <= 1'b0;
          estado  <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial: a cycle-level timing model pushes
// the expected result into a scoreboard when a start is accepted; the
// monitor pops it in the done cycle and checks handshake and hold behaviour.
module tb_subtrator_serial;

  localparam int N = 4;

  localparam int M_IDLE = 0;
  localparam int M_CALC = 1;
  localparam int M_FIM  = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         iniciar = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         ocupado;
  logic         pronto;
  logic [N-1:0] diferenca;
  logic         emprestimo;

  int checks = 0;
  int failures = 0;

  subtrator_serial #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iniciar    (iniciar),
    .a          (a),
    .b          (b),
    .ocupado    (ocupado),
    .pronto     (pronto),
    .diferenca  (diferenca),
    .emprestimo (emprestimo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference timing model and scoreboard.
  int           m_state = M_IDLE;
  int           m_cnt = 0;
  logic [N:0]   sb[$];
  logic [N:0]   entry;
  logic [N-1:0] ref_d;
  logic [N-1:0] hold_d = '0;
  logic         hold_e = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = M_IDLE;
      m_cnt   = 0;
      sb.delete();
      hold_d  = '0;
      hold_e  = 1'b0;
    end else begin
      case (m_state)
        M_IDLE: if (iniciar) begin
          ref_d = a - b;
          entry = {(a < b), ref_d};
          sb.push_back(entry);
          m_cnt   = 0;
          m_state = M_CALC;
        end
        M_CALC: if (m_cnt == N - 1) m_state = M_FIM; else m_cnt++;
        default: m_state = M_IDLE;
      endcase
    end
  end

  // Monitor: sample on the falling edge, away from DUT updates.
  int   cyc_n = 0;
  int   last_p = 0;
  bit   last_p_valid = 0;
  bit   period_mode = 0;
  int   n_periods = 0;
  logic [N:0] popped;

  always @(negedge clk) begin
    cyc_n++;
    check("ocupado", {31'd0, ocupado}, {31'd0, m_state == M_CALC});
    check("pronto", {31'd0, pronto}, {31'd0, m_state == M_FIM});
    if (m_state == M_FIM) begin
      check("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
        popped = sb.pop_front();
        hold_d = popped[N-1:0];
        hold_e = popped[N];
      end
    end
    check("diferenca", {28'd0, diferenca}, {28'd0, hold_d});
    check("emprestimo", {31'd0, emprestimo}, {31'd0, hold_e});
    if (pronto) begin
      if (period_mode && last_p_valid) begin
        check("period", cyc_n - last_p, N + 2);
        n_periods++;
      end
      last_p = cyc_n;
      last_p_valid = 1;
    end
  end

  // Called just after a rising edge with the DUT idle; returns on the edge
  // at which the DUT is back in its idle state.
  task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb);
    #1;
    a = va;
    b = vb;
    iniciar = 1'b1;
    @(posedge clk);
    #1 iniciar = 1'b0;
    repeat (N + 1) @(posedge clk);
  endtask

  int lat;
  int busy;

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ocupado", {31'd0, ocupado}, 0);
    check("rst_pronto", {31'd0, pronto}, 0);
    check("rst_dif", {28'd0, diferenca}, 0);
    check("rst_emp", {31'd0, emprestimo}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);

    // 9 - 5: latency, busy length and result.
    #1;
    a = 4'd9;
    b = 4'd5;
    iniciar = 1'b1;
    @(posedge clk);
    #1 iniciar = 1'b0;
    lat = 0;
    busy = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ocupado) busy++;
      if (pronto) begin
        lat = k;
        break;
      end
    end
    check("t1_latency", lat, N + 1);
    check("t1_busy", busy, N);
    check("t1_dif", {28'd0, diferenca}, 4);
    check("t1_emp", {31'd0, emprestimo}, 0);
    @(posedge clk);

    // Borrow cases and boundary operands.
    run_op(4'd5, 4'd9);
    #1 check("t2_dif", {28'd0, diferenca}, 12);
    check("t2_emp", {31'd0, emprestimo}, 1);
    run_op(4'd0, 4'd1);
    #1 check("t3_dif", {28'd0, diferenca}, 15);
    check("t3_emp", {31'd0, emprestimo}, 1);
    run_op(4'd15, 4'd15);
    #1 check("t4_dif", {28'd0, diferenca}, 0);
    check("t4_emp", {31'd0, emprestimo}, 0);
    run_op(4'd15, 4'd0);
    #1 check("t5_dif", {28'd0, diferenca}, 15);
    check("t5_emp", {31'd0, emprestimo}, 0);

    // Exhaustive sweep; the monitor compares each result with the model.
    for (int i = 0; i < 256; i++) begin
      run_op(4'(i >> 4), 4'(i));
    end

    // Start requests and operand changes during CALCULA and FIM are ignored.
    #1;
    a = 4'd9;
    b = 4'd5;
    iniciar = 1'b1;
    @(posedge clk);
    for (int k = 0; k < N + 1; k++) begin
      #1;
      iniciar = 1'b1;
      if (k % 2 == 0) begin
        a = 4'd1;
        b = 4'd2;
      end else begin
        a = 4'($urandom_range(15));
        b = 4'($urandom_range(15));
      end
      @(posedge clk);
    end
    #1 iniciar = 1'b0;
    check("ign_dif", {28'd0, diferenca}, 4);
    check("ign_emp", {31'd0, emprestimo}, 0);
    @(posedge clk);

    // Asynchronous reset in the middle of an operation.
    #1;
    a = 4'd7;
    b = 4'd3;
    iniciar = 1'b1;
    @(posedge clk);
    #1 iniciar = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_ocupado", {31'd0, ocupado}, 0);
    check("arst_pronto", {31'd0, pronto}, 0);
    check("arst_dif", {28'd0, diferenca}, 0);
    check("arst_emp", {31'd0, emprestimo}, 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) @(posedge clk);
    run_op(4'd3, 4'd7);
    #1 check("post_rst_dif", {28'd0, diferenca}, 12);
    check("post_rst_emp", {31'd0, emprestimo}, 1);

    // iniciar held high: back-to-back operations every N+2 cycles.
    period_mode = 1;
    last_p_valid = 0;
    a = 4'd6;
    b = 4'd2;
    iniciar = 1'b1;
    repeat (4 * (N + 2)) @(posedge clk);
    #1 iniciar = 1'b0;
    repeat (2 * (N + 2)) @(posedge clk);
    period_mode = 0;
    check("held_periods", {31'd0, n_periods >= 2}, 1);
    check("held_dif", {28'd0, diferenca}, 4);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subtrator_serial.md
# subtrator_serial

Bit-serial N-bit subtractor computing a − b one bit per clock, LSB first, with a start/done handshake. It is the subtraction counterpart of the team's ripple-carry adder: where the adder resolves all bits combinationally through chained one-bit cells, this block reuses a single one-bit borrow cell over N cycles. It sits alongside the adder in the arithmetic datapath, and its result registers hold the last difference until a new operation completes.

## Interface
- N, default 4, operand and difference width in bits (N ≥ 2)
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- iniciar  input  1  start request, sampled only in state OCIOSO
- a  input  N  minuend, captured on an accepted start
- b  input  N  subtrahend, captured on an accepted start
- ocupado  output  1  high while an operation is in progress (CALCULA)
- pronto  output  1  one-cycle pulse marking a completed result
- diferenca  output  N  (a − b) mod 2^N from the last completed operation
- emprestimo  output  1  final borrow from the last completed operation; 1 iff a < b (unsigned)

## Operation
- FSM states: OCIOSO, CALCULA, FIM.
- OCIOSO: if iniciar = 1, then:
  - capture a and b into internal shift registers
  - clear the borrow flop and the bit counter
  - go to CALCULA
- If iniciar = 0, stay in OCIOSO.
- CALCULA, processing bit i (counter = i, from 0 to N−1), with ai and bi the current LSBs of the shift registers:
  - d = ai ^ bi ^ br
  - br' = (~ai & bi) | (~(ai ^ bi) & br)
  - shift d into the MSB of a result shift register (right shift)
  - shift both operand registers right by one
  - increment the counter
- On the last bit (counter = N−1), go to FIM. On that same edge, load diferenca from the completed result and emprestimo from br'.
- FIM: pronto = 1 for exactly this cycle. Return to OCIOSO unconditionally. iniciar is ignored in FIM.
- iniciar is ignored while in CALCULA. An in-flight operation is never restarted or corrupted, and its captured operands are unaffected by later changes on a or b.
- diferenca and emprestimo change only on the edge entering FIM. They are stable at all other times, including during a following operation.
- Counter width is ceil(log2 N); no wrap occurs beyond N−1.

## Timing
- Reset (rst_n = 0, asynchronous) forces:
  - state OCIOSO
  - ocupado = 0, pronto = 0
  - diferenca = 0, emprestimo = 0
  - counter, borrow and shift registers = 0
- Reset mid-operation aborts the operation. No pronto pulse is produced afterward, and the outputs read 0.
- Start accepted at edge T (state OCIOSO, iniciar = 1):
  - CALCULA occupies cycles T+1 through T+N
  - ocupado = 1 in those N cycles
  - FIM is the cycle after T+N, with pronto = 1 and the new diferenca/emprestimo valid
- Latency: N+1 cycles from start acceptance to pronto. Throughput: one operation per N+2 cycles.
- ocupado and pronto are registered, decoded from state flops with no combinational path from inputs.
- iniciar held high continuously starts a new operation on every OCIOSO cycle, i.e. every N+2 cycles.

## Test plan
- Reset, then a = 9, b = 5, one-cycle iniciar -> ocupado high for 4 cycles; pronto pulses exactly 5 cycles after acceptance; diferenca = 4, emprestimo = 0.
- a = 5, b = 9 -> diferenca = 12 (0xC), emprestimo = 1. Also a = 0, b = 1 -> diferenca = 15, emprestimo = 1.
- Boundary operands: a = 15, b = 15 -> diferenca = 0, emprestimo = 0; a = 15, b = 0 -> diferenca = 15, emprestimo = 0. Then exhaustive 256-pair sweep against the reference model (a − b) mod 16 with borrow = (a < b).
- Start 9 − 5, then pulse iniciar with a = 1, b = 2 during CALCULA and during FIM, and change a/b every cycle -> result still 4/0; exactly one pronto; no second operation begins until OCIOSO.
- Start 7 − 3 and assert rst_n = 0 asynchronously, mid-cycle, after 2 CALCULA cycles -> all outputs 0 immediately; no pronto after release; the next start of 3 − 7 gives diferenca = 12, emprestimo = 1.
- iniciar held high with a = 6, b = 2 -> pronto pulses every 6 cycles; diferenca stays 4 between pulses and does not glitch during CALCULA.
